regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file for the next-generation core.
//  - NRD read ports, NWR write ports, optional same-cycle write-to-read bypass.
//  - Per-register busy scoreboard used by the decode stage for hazard detection.
//  - Sequential bulk-clear engine for a soft reset.
//  - Sits between decode (reads, issue) and writeback (writes); replaces the 2R/1W file.
// PARAMETERS
//  XLEN     32  data width in bits
//  NREGS    32  number of architectural registers (power of two)
//  AW       5   address width, $clog2(NREGS)
//  NRD      2   number of read ports (1..4)
//  NWR      2   number of write ports (1..2)
//  BYPASS   1   1: read of a register written this cycle returns the new data
//  ZERO_REG 1   1: register 0 reads as 0, ignores writes, and is never busy
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous reset, active-low
//  wen        in   NWR       write enable per write port
//  waddr      in   NWR*AW    write addresses, port p at [p*AW +: AW]
//  wdata      in   NWR*XLEN  write data, port p at [p*XLEN +: XLEN]
//  raddr      in   NRD*AW    read addresses
//  rdata      out  NRD*XLEN  read data, combinational
//  rbusy      out  NRD       busy bit of each read address, combinational
//  iss_valid  in   1         instruction issued; marks iss_rd busy
//  iss_rd     in   AW        destination register of the issued instruction
//  sb_flush   in   1         clear all busy bits (pipeline flush)
//  clr_start  in   1         start bulk clear (one pulse)
//  clr_busy   out  1         bulk clear in progress
// BEHAVIOUR
//  Reset (async, rst_n=0): all registers = 0; busy = 0; FSM = IDLE; clr_busy = 0; clear counter = 0.
//  Write: on posedge, for each p with wen[p]=1, regs[waddr[p]] <= wdata[p].
//  - Same address on two ports: the higher port index wins.
//  - With ZERO_REG=1, writes to address 0 are dropped.
//  Read: rdata[i] = regs[raddr[i]], zero latency. Address 0 returns 0 when ZERO_REG=1.
//  - With BYPASS=1, a matching enabled write this cycle is forwarded, using the same winner rule.
//  Scoreboard, evaluated in order at each posedge:
//  - (1) A write with wen[p] clears busy[waddr[p]].
//  - (2) iss_valid sets busy[iss_rd]. Setting wins over clearing on the same register in the same cycle.
//  - (3) sb_flush clears every bit. It overrides (1) and (2).
//  - rbusy[i] = busy[raddr[i]]; this is NOT bypassed by same-cycle writes.
//  - With ZERO_REG=1, busy[0] is held at 0.
//  Clear FSM:
//  - IDLE -> CLEAR on clr_start: counter = 0, clr_busy = 1 from the next cycle.
//  - CLEAR: each cycle regs[counter] <= 0 and busy[counter] <= 0, then counter increments.
//  - After clearing NREGS-1: -> IDLE and clr_busy = 0. Total NREGS cycles; the counter wraps to 0.
//  - In CLEAR, external writes are ignored and iss_valid is ignored; the decoder stalls on clr_busy.
//  - clr_start while in CLEAR is ignored (no restart).
//  - Reads in CLEAR return current contents. Registers not yet cleared keep their old data.
//  - rst_n assertion mid-clear: immediate return to IDLE with everything zeroed.
// STRUCTURE
//  Shared package/defines: XLEN, NREGS, AW defaults, and FSM state encoding (IDLE = 1'b0, CLEAR = 1'b1).
//  One sub-module, regfile_sb, holds the busy vector plus the set/clear/flush priority logic.
//  Storage, write-port arbitration, bypass muxes and the clear FSM are in regfile_mp.
// TESTING
//  1 Reset then read every address on all ports -> rdata = 0, rbusy = 0, clr_busy = 0.
//  2 Dual write, same cycle: p0 x5 = 0x11, p1 x5 = 0x22.
//    -> next cycle x5 = 0x22. With BYPASS=1 a same-cycle read of x5 returns 0x22.
//  3 Write 0xDEADBEEF to x0 -> x0 reads 0. Issue to x0 -> rbusy for x0 stays 0.
//  4 Scoreboard:
//    - iss x7 -> rbusy = 1.
//    - Later wen x7 and iss x7 in the same cycle -> stays 1.
//    - wen x7 alone -> 0.
//    - iss x3 with sb_flush -> 0.
//  5 Fill regs with 0xA5A5A5A5 and pulse clr_start -> clr_busy high exactly 32 cycles.
//    - Writes during this window are dropped; afterwards all regs read 0.
//  6 Assert rst_n low at clear cycle 10 -> clr_busy = 0 immediately and all regs 0.
//    - A new clr_start afterwards completes normally.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared defaults and clear-engine state encoding for the multi-port register file.
package regfile_mp_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_sb.sv
// Busy scoreboard: per-register busy bits with write-clear, issue-set, bulk-clear and flush priority.
module regfile_sb
  import regfile_mp_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int AW       = $clog2(NREGS),
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NWR-1:0]   wen,
  input  logic [NWR*AW-1:0] waddr,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic             sb_flush,
  input  logic             clr_active,
  input  logic [AW-1:0]    clr_idx,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_d;

  // Later assignments take priority: write clear < issue set < clear engine < flush.
  always_comb begin
    busy_d = busy;
    for (int p = 0; p < NWR; p++) begin
      if (wen[p]) busy_d[waddr[p*AW +: AW]] = 1'b0;
    end
    if (iss_valid) busy_d[iss_rd] = 1'b1;
    if (clr_active) busy_d[clr_idx] = 1'b0;
    if (sb_flush) busy_d = '0;
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_d;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write bypass, busy scoreboard and sequential bulk clear.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int AW       = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    wen,
  input  logic [NWR*AW-1:0] waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              sb_flush,
  input  logic              clr_start,
  output logic              clr_busy
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  clr_state_t       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [NWR-1:0]   wen_eff;
  logic             iss_eff;

  assign clr_busy = (state_q == CLEAR);
  // The decoder stalls during a clear, so writes and issues arriving then are discarded.
  assign wen_eff  = clr_busy ? '0 : wen;
  assign iss_eff  = iss_valid && !clr_busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ports are visited in ascending order so the highest enabled port wins a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wen_eff[p] && !(ZERO_REG && waddr[p*AW +: AW] == '0))
          regs[waddr[p*AW +: AW]] <= wdata[p*XLEN +: XLEN];
      end
      if (clr_busy) regs[cnt_q] <= '0;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      rdata[i*XLEN +: XLEN] = regs[raddr[i*AW +: AW]];
      if (BYPASS) begin
        for (int p = 0; p < NWR; p++) begin
          if (wen_eff[p] && waddr[p*AW +: AW] == raddr[i*AW +: AW])
            rdata[i*XLEN +: XLEN] = wdata[p*XLEN +: XLEN];
        end
      end
      if (ZERO_REG && raddr[i*AW +: AW] == '0) rdata[i*XLEN +: XLEN] = '0;
      rbusy[i] = busy[raddr[i*AW +: AW]];
    end
  end

  regfile_sb #(
    .NREGS   (NREGS),
    .AW      (AW),
    .NWR     (NWR),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen_eff),
    .waddr     (waddr),
    .iss_valid (iss_eff),
    .iss_rd    (iss_rd),
    .sb_flush  (sb_flush),
    .clr_active(clr_busy),
    .clr_idx   (cnt_q),
    .busy      (busy)
  );

endmodule
